fact_accel: RTL and testbench

Memory-mapped factorial accelerator. It sits on the data-memory bus downstream of `mips_top`, behind the SoC address decoder. The processor writes an operand and a start command through its store path (`we_dm`, `alu_out`, `wd_dm`), polls status, then reads the 32-bit result back on the load path (`rd_dm`). Computation is iterative: one multiply per cycle.

---
 rtl/fact_accel.sv | 169 ++++++++++++++++
 tb/tb_fact_accel.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel.sv
// -----------------------------------------------------------------------------
// fact_accel -- memory-mapped iterative factorial accelerator
//
// The processor stores an operand N and a GO command on the data-memory
// store path. It polls STATUS and then loads the 32-bit RESULT. The datapath
// does one 32x32 multiply per cycle and keeps the low 32 bits. A GO with
// N > MAX_N does not start a computation. It sets the error flag at once.
//
// Word map (a = alu_out[3:2]):
//   0 N       rw  operand, zero-extended on read
//   1 GO      w   bit0 = start; bit1 = interrupt enable (IRQ build only)
//               r   {31'b0, busy}
//   2 STATUS  r   {29'b0, ie, err, done}  (ie reads 0 without IRQ build)
//   3 RESULT  r   last completed result
//
// Ports:
//   clk   in   1   single clock, rising edge
//   rst   in   1   asynchronous, active-high reset
//   we    in   1   decoded write enable
//   a     in   2   word select
//   wd    in  32   write data
//   rd    out 32   combinational read data
//   irq   out  1   done & ie (present only when FACT_ACCEL_IRQ_EN is defined)
//
// Configuration macro: FACT_ACCEL_IRQ_EN adds the interrupt-enable register
// and the irq output.
// -----------------------------------------------------------------------------
module fact_accel #(
    parameter int N_W   = 4,
    parameter int MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
`ifdef FACT_ACCEL_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        ADDR_N      = 2'd0,
        ADDR_GO     = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_RESULT = 2'd3
    } addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [31:0] MAX_N_U = 32'(MAX_N);

    state_t           state;
    logic [N_W-1:0]   n_r;
    logic [N_W-1:0]   cnt;
    logic [31:0]      prod;
    logic [31:0]      result;
    logic             done;
    logic             err;
    logic             busy;
    logic             ie_bit;

    logic             wr_n;
    logic             wr_go;
    logic             go_start;

    assign busy     = (state == BUSY);
    assign wr_n     = we && (a == ADDR_N);
    assign wr_go    = we && (a == ADDR_GO);
    assign go_start = wr_go && wd[0];

`ifdef FACT_ACCEL_IRQ_EN
    logic ie;

    // The enable is written by every GO write, whether or not the engine is
    // busy and regardless of the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (wr_go) begin
            ie <= wd[1];
        end
    end

    assign ie_bit = ie;
    assign irq    = done & ie;
`else
    assign ie_bit = 1'b0;
`endif

    // Upper write-data bits carry no state in this block.
    logic unused_wd;
    assign unused_wd = ^wd[31:N_W];

    // Control and datapath state.
    // NOTE: every register here is assigned with <= so all of them sample
    // the pre-edge values of one another. prod*cnt uses the old cnt, and
    // result <= prod captures the final product, not a half-updated one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            n_r    <= '0;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_n) begin
                        n_r <= wd[N_W-1:0];
                    end
                    if (go_start) begin
                        if (32'(n_r) > MAX_N_U) begin
                            // Out-of-range operand: report it and never start.
                            err    <= 1'b1;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            err   <= 1'b0;
                            done  <= 1'b0;
                            cnt   <= n_r;
                            prod  <= 32'd1;
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    // n = 0 and n = 1 fall straight through to completion
                    // with prod = 1, so both take a single busy cycle.
                    if (cnt > N_W'(1)) begin
                        prod <= prod * 32'(cnt);
                        cnt  <= cnt - N_W'(1);
                    end else begin
                        result <= prod;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read mux is purely combinational and has no side effects.
    // NOTE: rd gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rd = '0;
        case (a)
            ADDR_N:      rd = 32'(n_r);
            ADDR_GO:     rd = {31'b0, busy};
            ADDR_STATUS: rd = {29'b0, ie_bit, err, done};
            ADDR_RESULT: rd = result;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// -----------------------------------------------------------------------------
// tb_fact_accel -- self-checking bench for fact_accel
//
// The bench drives inputs and reads rd only while clk is low. The DUT
// samples on the rising edge, so stimulus and checks stay clear of it.
// Expected results come from constant tables and from a factorial model
// that uses plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fact_accel;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fact_accel dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
`ifdef FACT_ACCEL_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: n! truncated to 32 bits; out-of-range operands yield 0.
    function automatic logic [31:0] model_fact(input int n);
        logic [31:0] f;
        if (n > 12) return 32'd0;
        f = 32'd1;
        for (int i = 2; i <= n; i++) f = f * 32'(i);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] val);
        a = addr;
        #1;
        val = rd;
    endtask

    // One write: inputs are set in the low phase and sampled on the next
    // rising edge. The task returns at the following falling edge.
    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        wd = 32'd0;
    endtask

    task automatic run_op(input int n, input logic [31:0] exp_res, input logic exp_err,
                          input string name);
        logic [31:0] v;
        int cyc;
        int want;
        do_write(2'd0, 32'(n));
        rd_reg(2'd0, v);
        check({name, " n readback"}, v, 32'(n));
        do_write(2'd1, 32'h1);
        if (exp_err) begin
            rd_reg(2'd2, v);
            check({name, " err status"}, v, 32'h3);
            rd_reg(2'd1, v);
            check({name, " err busy"}, v, 32'h0);
            rd_reg(2'd3, v);
            check({name, " err result"}, v, 32'h0);
            tick();
            rd_reg(2'd1, v);
            check({name, " err busy later"}, v, 32'h0);
        end else begin
            rd_reg(2'd1, v);
            check({name, " busy after go"}, v, 32'h1);
            cyc = 0;
            forever begin
                tick();
                cyc++;
                rd_reg(2'd1, v);
                if (v == 32'h0 || cyc >= 40) break;
                rd_reg(2'd2, v);
                check({name, " status while busy"}, v, 32'h0);
            end
            want = (n < 1) ? 1 : n;
            check({name, " cycles"}, 32'(cyc), 32'(want));
            rd_reg(2'd2, v);
            check({name, " status done"}, v, 32'h1);
            rd_reg(2'd3, v);
            check({name, " result"}, v, exp_res);
        end
    endtask

    initial begin
        logic [31:0] v;
        int rn;

        tbl[0] = '{n: 5,  res: 32'h0000_0078, err: 1'b0};
        tbl[1] = '{n: 12, res: 32'h1C8C_FC00, err: 1'b0};
        tbl[2] = '{n: 0,  res: 32'h0000_0001, err: 1'b0};
        tbl[3] = '{n: 1,  res: 32'h0000_0001, err: 1'b0};
        tbl[4] = '{n: 13, res: 32'h0000_0000, err: 1'b1};
        tbl[5] = '{n: 3,  res: 32'h0000_0006, err: 1'b0};
        tbl[6] = '{n: 7,  res: 32'h0000_13B0, err: 1'b0};
        tbl[7] = '{n: 15, res: 32'h0000_0000, err: 1'b1};

        rst = 1'b1;
        we  = 1'b0;
        a   = 2'd0;
        wd  = 32'd0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            check($sformatf("reset read a=%0d", i), v, 32'h0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            check($sformatf("post-reset read a=%0d", i), v, 32'h0);
        end
`ifdef FACT_ACCEL_IRQ_EN
        check("reset irq", 32'(irq), 32'h0);
`endif

        // Table-driven operands, including the boundaries 0, 1, 12 and 13.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].n, tbl[i].res, tbl[i].err, $sformatf("tbl n=%0d", tbl[i].n));
        end

        // Writes to N and GO while busy must be ignored.
        do_write(2'd0, 32'd6);
        do_write(2'd1, 32'h1);
        tick();
        do_write(2'd0, 32'd3);
        do_write(2'd1, 32'h1);
        rd_reg(2'd0, v);
        check("busy-ignore n holds", v, 32'd6);
        rd_reg(2'd1, v);
        check("busy-ignore still busy", v, 32'h1);
        tick();
        tick();
        rd_reg(2'd1, v);
        check("busy-ignore busy at k+5", v, 32'h1);
        tick();
        rd_reg(2'd1, v);
        check("busy-ignore idle at k+6", v, 32'h0);
        rd_reg(2'd3, v);
        check("busy-ignore result", v, 32'h2D0);
        rd_reg(2'd0, v);
        check("busy-ignore n final", v, 32'd6);

        // Asynchronous reset mid-computation clears everything at once.
        do_write(2'd0, 32'd10);
        do_write(2'd1, 32'h1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            check($sformatf("abort read a=%0d", i), v, 32'h0);
        end
`ifdef FACT_ACCEL_IRQ_EN
        check("abort irq", 32'(irq), 32'h0);
`endif
        rst = 1'b0;
        tick();
        run_op(4, 32'd24, 1'b0, "after abort n=4");

        // A read during a write to the same word shows the pre-edge value.
        we = 1'b1;
        a  = 2'd0;
        wd = 32'd9;
        #1;
        check("rd during write", rd, 32'd4);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rd_reg(2'd0, v);
        check("rd after write", v, 32'd9);

        // GO without the start bit, and writes to read-only words, do nothing.
        do_write(2'd1, 32'h0);
        rd_reg(2'd1, v);
        check("go0 no start", v, 32'h0);
        do_write(2'd3, 32'hFFFF_FFFF);
        do_write(2'd2, 32'h0);
        rd_reg(2'd2, v);
        check("ro write status", v, 32'h1);
        rd_reg(2'd3, v);
        check("ro write result", v, 32'd24);

        // Interrupt-enable sequence. Without the IRQ build, bit 1 is ignored.
        do_write(2'd0, 32'd3);
        do_write(2'd1, 32'h3);
        rd_reg(2'd1, v);
        check("ie-run busy", v, 32'h1);
`ifdef FACT_ACCEL_IRQ_EN
        check("ie-run irq low while busy", 32'(irq), 32'h0);
`endif
        tick();
        tick();
        rd_reg(2'd1, v);
        check("ie-run busy at k+2", v, 32'h1);
        tick();
        rd_reg(2'd1, v);
        check("ie-run idle at k+3", v, 32'h0);
        rd_reg(2'd2, v);
`ifdef FACT_ACCEL_IRQ_EN
        check("ie-run status", v, 32'h5);
        check("ie-run irq high", 32'(irq), 32'h1);
`else
        check("ie-run status", v, 32'h1);
`endif
        rd_reg(2'd3, v);
        check("ie-run result", v, 32'd6);
        do_write(2'd1, 32'h3);
        rd_reg(2'd2, v);
`ifdef FACT_ACCEL_IRQ_EN
        check("ie-rego status", v, 32'h4);
        check("ie-rego irq dropped", 32'(irq), 32'h0);
`else
        check("ie-rego status", v, 32'h0);
`endif
        tick();
        tick();
        tick();
        rd_reg(2'd3, v);
        check("ie-rego result", v, 32'd6);

        // Random operands compared against the reference model.
        for (int i = 0; i < 25; i++) begin
            rn = int'($urandom_range(0, 15));
            run_op(rn, model_fact(rn), (rn > 12), $sformatf("rand%0d n=%0d", i, rn));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
